// File: rtl/tx_ts_pkg.sv
// tx_ts_pkg: shared state encoding and default widths for the TX-start
// timestamp handshake (destination capture and source-side checker).
package tx_ts_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACK     = 2'b01,
        ST_RELEASE = 2'b10
    } state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int TS_WIDTH_DEF    = 32;
endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: STAGES-deep flop chain bringing one asynchronous level into clk.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic aresetn,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) sync_q <= '0;
        else          sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/tx_start_ts_capture.sv
// tx_start_ts_capture: destination side of the TX-start 4-phase handshake; stamps each request.
// Define TX_TS_LATENCY_COMP_EN to back-date stamps by the synchroniser depth.
module tx_start_ts_capture
    import tx_ts_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TS_WIDTH    = TS_WIDTH_DEF,
    parameter int EVT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 tx_started_req,
    output logic                 tx_started_ack,
    input  logic                 ts_clear,
    output logic [TS_WIDTH-1:0]  ts_tdata,
    output logic                 ts_tvalid,
    input  logic                 ts_tready,
    output logic [EVT_WIDTH-1:0] event_count,
    output logic                 overrun
);
    state_e               state_q, state_d;
    logic                 ack_q, ack_d;
    logic [TS_WIDTH-1:0]  cnt_q, cnt_d, data_q, data_d, stamp;
    logic                 valid_q, valid_d, ovr_q, ovr_d;
    logic [EVT_WIDTH-1:0] evt_q, evt_d;
    logic                 req_sync, capture, can_load;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk    (clk),
        .aresetn(aresetn),
        .d_i    (tx_started_req),
        .q_o    (req_sync)
    );

`ifdef TX_TS_LATENCY_COMP_EN
    assign stamp = cnt_q - TS_WIDTH'(SYNC_STAGES);
`else
    assign stamp = cnt_q;
`endif

    always_comb begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = req_sync ? ST_ACK : ST_IDLE;
                ack_d   = req_sync;
                capture = req_sync;
            end
            ST_ACK: begin
                state_d = req_sync ? ST_ACK : ST_RELEASE;
                ack_d   = req_sync;
            end
            default: ;
        endcase
    end

    // A full buffer only frees up for a capture if the consumer takes it this cycle.
    assign can_load = !valid_q || ts_tready;
    assign valid_d  = capture || (valid_q && !ts_tready);
    assign data_d   = (capture && can_load) ? stamp : data_q;
    assign ovr_d    = ts_clear ? 1'b0 : (ovr_q || (capture && !can_load));
    assign evt_d    = ts_clear ? '0 : evt_q + EVT_WIDTH'(capture);
    assign cnt_d    = ts_clear ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            evt_q   <= evt_d;
        end
    end

    assign tx_started_ack = ack_q;
    assign ts_tdata       = data_q;
    assign ts_tvalid      = valid_q;
    assign event_count    = evt_q;
    assign overrun        = ovr_q;
endmodule

// File: tb/tb_tx_start_ts_capture.sv
// tb_tx_start_ts_capture: scoreboard bench; a second 8-bit-counter instance covers timestamp wrap.
module tb_tx_start_ts_capture;
    localparam int S = 2;

    logic        clk = 1'b0, aresetn = 1'b1;
    logic        req = 1'b0, ts_clear = 1'b0, ts_tready = 1'b0;
    logic        ack, ts_tvalid, ovr;
    logic [31:0] ts_tdata;
    logic [15:0] evt;
    logic        req8 = 1'b0, clr8 = 1'b0, rdy8 = 1'b1;
    logic        ack8, v8, ovr8;
    logic [7:0]  d8;
    logic [15:0] evt8;

    int          errors = 0, checks = 0;
    logic [31:0] mcnt;
    logic [7:0]  mcnt8;
    logic [31:0] sb[$];
    logic [7:0]  sb8[$];
    logic [31:0] exp32;
    logic [7:0]  exp8;

    tx_start_ts_capture #(.SYNC_STAGES(S), .TS_WIDTH(32), .EVT_WIDTH(16)) dut (
        .clk(clk), .aresetn(aresetn), .tx_started_req(req), .tx_started_ack(ack),
        .ts_clear(ts_clear), .ts_tdata(ts_tdata), .ts_tvalid(ts_tvalid),
        .ts_tready(ts_tready), .event_count(evt), .overrun(ovr)
    );

    tx_start_ts_capture #(.SYNC_STAGES(S), .TS_WIDTH(8), .EVT_WIDTH(16)) dut8 (
        .clk(clk), .aresetn(aresetn), .tx_started_req(req8), .tx_started_ack(ack8),
        .ts_clear(clr8), .ts_tdata(d8), .ts_tvalid(v8),
        .ts_tready(rdy8), .event_count(evt8), .overrun(ovr8)
    );

    always #5 clk = ~clk;

    // Reference free-running counters
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mcnt  <= '0;
            mcnt8 <= '0;
        end else begin
            mcnt  <= ts_clear ? 32'd0 : mcnt + 32'd1;
            mcnt8 <= mcnt8 + 8'd1;
        end
    end

    // Req raised after a negedge is captured on the 3rd following posedge,
    // whose pre-edge counter is c + S; compensation subtracts S again.
    function automatic logic [31:0] stamp32(input logic [31:0] c);
`ifdef TX_TS_LATENCY_COMP_EN
        return c + 32'(S) - 32'(S);
`else
        return c + 32'(S);
`endif
    endfunction

    task automatic handshake(input bit push);
        @(negedge clk);
        if (push) sb.push_back(stamp32(mcnt));
        req = 1'b1;
        repeat (S + 1) @(negedge clk);
        req = 1'b0;
        repeat (S + 2) @(negedge clk);
    endtask

    task automatic test_reset;
        #1 aresetn = 1'b0;
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({ack, ts_tvalid, evt, ovr} !== 19'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: ack=%b tvalid=%b evt=%0d ovr=%b, want all 0", i, ack, ts_tvalid, evt, ovr);
            end
        end
        checks++;
        if (ts_tdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_tdata: got %h want 0", ts_tdata);
        end
    endtask

    task automatic test_capture;
        ts_tready = 1'b1;
        @(negedge clk);
        sb.push_back(stamp32(mcnt));
        req = 1'b1;
        repeat (S) @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL cap_ack_early: got %b want 0", ack); end
        @(negedge clk);
        exp32 = sb.pop_front();
        checks++;
        if ({ack, ts_tvalid} !== 2'b11) begin errors++; $display("FAIL cap_ack_valid: ack=%b tvalid=%b want 1 1", ack, ts_tvalid); end
        checks++;
        if (ts_tdata !== exp32) begin errors++; $display("FAIL cap_tdata: got %h want %h", ts_tdata, exp32); end
        checks++;
        if (evt !== 16'd1) begin errors++; $display("FAIL cap_evt: got %0d want 1", evt); end
        @(negedge clk);
        checks++;
        if (ts_tvalid !== 1'b0) begin errors++; $display("FAIL cap_accept: tvalid=%b want 0", ts_tvalid); end
        req = 1'b0;
        repeat (S) @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL cap_ack_hold: got %b want 1", ack); end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL cap_ack_release: got %b want 0", ack); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overrun;
        ts_tready = 1'b0;
        ts_clear = 1'b1;
        @(negedge clk);
        ts_clear = 1'b0;
        handshake(1'b1);
        handshake(1'b0);
        exp32 = sb.pop_front();
        checks++;
        if ({ts_tvalid, ovr} !== 2'b11) begin errors++; $display("FAIL ovr_flags: tvalid=%b ovr=%b want 1 1", ts_tvalid, ovr); end
        checks++;
        if (ts_tdata !== exp32) begin errors++; $display("FAIL ovr_retained: got %h want %h", ts_tdata, exp32); end
        checks++;
        if (evt !== 16'd2) begin errors++; $display("FAIL ovr_evt: got %0d want 2", evt); end
        ts_tready = 1'b1;
        @(negedge clk);
        checks++;
        if ({ts_tvalid, ovr} !== 2'b01) begin errors++; $display("FAIL ovr_drain: tvalid=%b ovr=%b want 0 1", ts_tvalid, ovr); end
    endtask

    task automatic test_wrap;
        logic [7:0] target;
        bit hit;
`ifdef TX_TS_LATENCY_COMP_EN
        target = 8'hFF;
`else
        target = 8'(255 - S);
`endif
        for (int k = 0; k < 2; k++) begin
            hit = 1'b0;
            for (int i = 0; i < 300 && !hit; i++) begin
                @(negedge clk);
                hit = (mcnt8 == target);
            end
            checks++;
            if (!hit) begin errors++; $display("FAIL wrap_wait%0d: counter never reached %h", k, target); end
            sb8.push_back(k == 0 ? 8'hFF : 8'h00);
            req8 = 1'b1;
            repeat (S + 1) @(negedge clk);
            exp8 = sb8.pop_front();
            checks++;
            if ({v8, d8} !== {1'b1, exp8}) begin errors++; $display("FAIL wrap_stamp%0d: valid=%b data=%h want 1 %h", k, v8, d8, exp8); end
            req8 = 1'b0;
            repeat (S + 2) @(negedge clk);
            target = target + 8'd1;
        end
    endtask

    task automatic test_clear_capture;
        bit hit;
        ts_tready = 1'b1;
        ts_clear = 1'b1;
        @(negedge clk);
        ts_clear = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 600 && !hit; i++) begin
            if (stamp32(mcnt) == 32'd500) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL clr_wait: counter never reached target"); end
        sb.push_back(stamp32(mcnt));
        req = 1'b1;
        repeat (S) @(negedge clk);
        ts_clear = 1'b1;
        @(negedge clk);
        ts_clear = 1'b0;
        exp32 = sb.pop_front();
        checks++;
        if ({ts_tvalid, ts_tdata} !== {1'b1, exp32}) begin errors++; $display("FAIL clr_stamp: valid=%b data=%0d want 1 %0d", ts_tvalid, ts_tdata, exp32); end
        checks++;
        if ({evt, ovr} !== 17'd0) begin errors++; $display("FAIL clr_counts: evt=%0d ovr=%b want 0 0", evt, ovr); end
        req = 1'b0;
        repeat (S + 2) @(negedge clk);
        handshake(1'b1);
        exp32 = sb.pop_front();
        checks++;
        if (ts_tdata !== exp32) begin errors++; $display("FAIL clr_counter_zeroed: got %0d want %0d", ts_tdata, exp32); end
    endtask

    task automatic test_reset_mid;
        ts_tready = 1'b1;
        @(negedge clk);
        req = 1'b1;
        repeat (S + 1) @(negedge clk);
        checks++;
        if (ack !== 1'b1) begin errors++; $display("FAIL mid_ack_before: got %b want 1", ack); end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL mid_ack_async: got %b want 0", ack); end
        @(negedge clk);
        aresetn = 1'b1;
        sb.push_back(stamp32(mcnt));
        repeat (S) @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL mid_ack_early: got %b want 0", ack); end
        @(negedge clk);
        exp32 = sb.pop_front();
        checks++;
        if ({ack, evt} !== {1'b1, 16'd1}) begin errors++; $display("FAIL mid_recapture: ack=%b evt=%0d want 1 1", ack, evt); end
        checks++;
        if ({ts_tvalid, ts_tdata} !== {1'b1, exp32}) begin errors++; $display("FAIL mid_stamp: valid=%b data=%0d want 1 %0d", ts_tvalid, ts_tdata, exp32); end
        req = 1'b0;
        repeat (S + 2) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_capture;
        test_overrun;
        test_wrap;
        test_clear_capture;
        test_reset_mid;
        checks++;
        if (sb.size() != 0 || sb8.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d/%0d entries left", sb.size(), sb8.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
